// File: rtl/int_arb_pkg.sv
// Shared types and helpers for the interrupt claim arbiter: FSM states,
// ID/index conversion and the round-robin source picker.
package int_arb_pkg;

  typedef enum logic {IDLE, OFFER} arb_state_e;

  localparam int unsigned MAX_SRC = 15;
  localparam int NONE_ID = 0;

  function automatic int unsigned id2idx(input int unsigned id);
    return id - 1;
  endfunction

  function automatic int unsigned idx2id(input int unsigned idx);
    return idx + 1;
  endfunction

  // First set bit of pend strictly after ptr, wrapping at n; returns ptr if none.
  function automatic int unsigned rr_pick(input logic [MAX_SRC-1:0] pend,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic found;
    rr_pick = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k <= n) && pend[idx[3:0]]) begin
        rr_pick = idx;
        found = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/int_gateway.sv
// Per-source gateway: latches a level interrupt as pending and locks the
// source out while its claim is in flight.
module int_gateway (
  input  logic clock,
  input  logic reset,
  input  logic int_i,
  input  logic en_i,
  input  logic claim_hit_i,
  input  logic complete_hit_i,
  input  logic offer_hold_i,
  output logic pending_o,
  output logic in_flight_o
);

  logic pending_q, pending_d;
  logic in_flight_q, in_flight_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q   <= 1'b0;
      in_flight_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
    end
  end

  // A completion blocks the set path for one edge, so a still-high line re-pends afterwards.
  always_comb begin
    pending_d   = pending_q;
    in_flight_d = in_flight_q;
    if (claim_hit_i) begin
      pending_d   = 1'b0;
      in_flight_d = 1'b1;
    end else if (complete_hit_i) begin
      in_flight_d = 1'b0;
    end else if (pending_q && !en_i && !offer_hold_i) begin
      pending_d = 1'b0;
    end else if (int_i && en_i && !pending_q && !in_flight_q) begin
      pending_d = 1'b1;
    end
  end

  assign pending_o   = pending_q;
  assign in_flight_o = in_flight_q;

endmodule

// File: rtl/int_claim_arbiter.sv
// Round-robin interrupt claim arbiter: offers one pending source ID at a time
// over a valid/ready claim handshake and retires sources on completion writes.
module int_claim_arbiter
  import int_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_in,
  input  logic [N_SRC-1:0] int_en,
  output logic             irq_out,
  output logic             claim_valid,
  input  logic             claim_ready,
  output logic [ID_W-1:0]  claim_id,
  input  logic             complete_valid,
  input  logic [ID_W-1:0]  complete_id,
  output logic             complete_err
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] claim_id_q, claim_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;

  logic [N_SRC-1:0] pending, in_flight, claim_hit, complete_hit, offer_hold, eligible;
  logic             handshake;
  int unsigned      pick;

  // A source whose enable is dropping is not picked, so no stale ID gets offered.
  assign eligible  = pending & int_en;
  assign handshake = (state_q == OFFER) && claim_ready;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign offer_hold[g]   = (state_q == OFFER) && (claim_id_q == ID_W'(idx2id(g)));
    assign claim_hit[g]    = handshake && offer_hold[g];
    assign complete_hit[g] = complete_valid && (complete_id == ID_W'(idx2id(g))) && in_flight[g];

    int_gateway u_gw (
      .clock          (clock),
      .reset          (reset),
      .int_i          (int_in[g]),
      .en_i           (int_en[g]),
      .claim_hit_i    (claim_hit[g]),
      .complete_hit_i (complete_hit[g]),
      .offer_hold_i   (offer_hold[g]),
      .pending_o      (pending[g]),
      .in_flight_o    (in_flight[g])
    );
  end

  always_comb pick = rr_pick(MAX_SRC'(eligible), 32'(rr_ptr_q), N_SRC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      claim_id_q <= ID_W'(NONE_ID);
      rr_ptr_q   <= ID_W'(N_SRC - 1);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      claim_id_q <= claim_id_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          claim_id_d = ID_W'(idx2id(pick));
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (claim_ready) begin
          rr_ptr_d = ID_W'(id2idx(32'(claim_id_q)));
          state_d  = IDLE;
        end
      end
    endcase
  end

  // Anything that did not retire an in-flight source is flagged, including the ID on offer.
  assign err_d = complete_valid && !(|complete_hit);

  always_comb begin
    claim_valid  = (state_q == OFFER);
    claim_id     = claim_valid ? claim_id_q : ID_W'(NONE_ID);
    irq_out      = |pending;
    complete_err = err_q;
  end

endmodule

// File: tb/tb_int_claim_arbiter.sv
// Self-checking bench for int_claim_arbiter: a per-source behavioural model
// is compared with the DUT every cycle, plus directed literal expectations.
module tb_int_claim_arbiter;

  localparam int N   = 4;
  localparam int IDW = 3;

  logic           clock, reset;
  logic [N-1:0]   int_in, int_en;
  logic           claim_ready, complete_valid;
  logic [IDW-1:0] complete_id;
  logic           irq_out, claim_valid, complete_err;
  logic [IDW-1:0] claim_id;

  int total = 0;
  int bad   = 0;

  bit mPend[N];
  bit mInfl[N];
  bit mOffer;
  int mOffIdx;
  int mPtr;
  bit mErr;

  int hsLog[$];

  int_claim_arbiter #(.N_SRC(N), .ID_W(IDW)) dut (
    .clock          (clock),
    .reset          (reset),
    .int_in         (int_in),
    .int_en         (int_en),
    .irq_out        (irq_out),
    .claim_valid    (claim_valid),
    .claim_ready    (claim_ready),
    .claim_id       (claim_id),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .complete_err   (complete_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mPend[i] = 1'b0;
      mInfl[i] = 1'b0;
    end
    mOffer  = 1'b0;
    mOffIdx = 0;
    mPtr    = N - 1;
    mErr    = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit np[N];
    bit ni[N];
    bit hs, chit, found;
    int cidx, k;
    hs   = mOffer && claim_ready;
    cidx = int'(complete_id) - 1;
    chit = 1'b0;
    if (complete_valid && complete_id >= 1 && complete_id <= N)
      if (mInfl[cidx]) chit = 1'b1;
    for (int i = 0; i < N; i++) begin
      np[i] = mPend[i];
      ni[i] = mInfl[i];
      if (hs && mOffIdx == i) begin
        np[i] = 1'b0;
        ni[i] = 1'b1;
      end else if (chit && cidx == i) begin
        ni[i] = 1'b0;
      end else if (mPend[i] && !int_en[i] && !(mOffer && mOffIdx == i)) begin
        np[i] = 1'b0;
      end else if (int_in[i] && int_en[i] && !mPend[i] && !mInfl[i]) begin
        np[i] = 1'b1;
      end
    end
    if (!mOffer) begin
      found = 1'b0;
      for (int j = 1; j <= N; j++) begin
        k = (mPtr + j) % N;
        if (!found && mPend[k] && int_en[k]) begin
          found   = 1'b1;
          mOffer  = 1'b1;
          mOffIdx = k;
        end
      end
    end else if (hs) begin
      mPtr   = mOffIdx;
      mOffer = 1'b0;
    end
    mErr = complete_valid && !chit;
    for (int i = 0; i < N; i++) begin
      mPend[i] = np[i];
      mInfl[i] = ni[i];
    end
  endtask

  task automatic checkOutput();
    logic           anyP;
    logic [IDW-1:0] expId;
    anyP = 1'b0;
    for (int i = 0; i < N; i++) anyP |= mPend[i];
    expId = mOffer ? IDW'(mOffIdx + 1) : '0;
    cmp("irq_out", irq_out, anyP);
    cmp("claim_valid", claim_valid, mOffer);
    cmp("claim_id", claim_id, expId);
    cmp("complete_err", complete_err, mErr);
  endtask

  task automatic applyStimulus();
    if (claim_valid && claim_ready && !reset) hsLog.push_back(int'(claim_id));
    modelStep();
    @(posedge clock);
    #1 checkOutput();
  endtask

  task automatic applyReset();
    reset          = 1'b1;
    int_in         = '0;
    int_en         = '1;
    claim_ready    = 1'b0;
    complete_valid = 1'b0;
    complete_id    = '0;
    modelReset();
    repeat (2) begin
      @(posedge clock);
      #1 checkOutput();
    end
    reset = 1'b0;
  endtask

  task automatic midCycleReset();
    #2 reset = 1'b1;
    #1 modelReset();
    checkOutput();
    cmp("async_drop_valid", claim_valid, 0);
    #2 reset = 1'b0;
    complete_valid = 1'b0;
  endtask

  function automatic int firstInflight();
    for (int i = 0; i < N; i++) if (mInfl[i]) return i + 1;
    return 0;
  endfunction

  function automatic int randInflight();
    int ids[$];
    for (int i = 0; i < N; i++) if (mInfl[i]) ids.push_back(i + 1);
    if (ids.size() == 0) return 0;
    return ids[$urandom_range(0, ids.size() - 1)];
  endfunction

  initial begin
    int expSeq[6];
    int id, r;
    expSeq = '{1, 2, 3, 4, 1, 2};

    // Reset values and single-source latency
    applyReset();
    cmp("rst_irq", irq_out, 0);
    cmp("rst_valid", claim_valid, 0);
    cmp("rst_id", claim_id, 0);
    cmp("rst_err", complete_err, 0);

    int_in = 4'b0010;
    claim_ready = 1'b1;
    applyStimulus();
    cmp("lat_irq", irq_out, 1);
    cmp("lat_valid_early", claim_valid, 0);
    applyStimulus();
    cmp("lat_valid", claim_valid, 1);
    cmp("lat_id", claim_id, 2);
    applyStimulus();
    repeat (4) begin
      applyStimulus();
      cmp("no_reoffer", claim_valid, 0);
    end
    complete_valid = 1'b1;
    complete_id    = 3'd2;
    applyStimulus();
    complete_valid = 1'b0;
    applyStimulus();
    cmp("repend_irq", irq_out, 1);
    applyStimulus();
    cmp("reoffer_id", claim_id, 2);

    // All sources high with immediate completions: round-robin order
    applyReset();
    hsLog.delete();
    int_in = 4'b1111;
    claim_ready = 1'b1;
    repeat (16) begin
      id = firstInflight();
      complete_valid = (id != 0);
      complete_id    = IDW'(id);
      applyStimulus();
    end
    complete_valid = 1'b0;
    cmp("rr_count_ge6", (hsLog.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6; i++)
      if (i < hsLog.size()) cmp("rr_order", hsLog[i], expSeq[i]);

    // Offer held stable while target stalls
    applyReset();
    int_in = 4'b0001;
    applyStimulus();
    applyStimulus();
    cmp("hold_first_valid", claim_valid, 1);
    cmp("hold_first_id", claim_id, 1);
    int_in = 4'b0101;
    repeat (5) begin
      applyStimulus();
      cmp("hold_valid", claim_valid, 1);
      cmp("hold_id", claim_id, 1);
    end
    claim_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    cmp("next_id", claim_id, 3);
    claim_ready = 1'b0;

    // Invalid completions: ID 0, out of range, idle source, source on offer
    complete_valid = 1'b1;
    complete_id = 3'd0; applyStimulus(); cmp("err_id0", complete_err, 1);
    complete_id = 3'd5; applyStimulus(); cmp("err_id5", complete_err, 1);
    complete_id = 3'd2; applyStimulus(); cmp("err_idle", complete_err, 1);
    complete_id = 3'd3; applyStimulus(); cmp("err_offer", complete_err, 1);
    complete_id = 3'd1; applyStimulus(); cmp("ok_complete", complete_err, 0);

    // Completed source still high re-pends and is re-offered
    complete_valid = 1'b0;
    claim_ready = 1'b1;
    applyStimulus();
    applyStimulus();
    cmp("repend_offer_id", claim_id, 1);

    // Async reset during an offer with two sources in flight
    applyReset();
    int_in = 4'b0101;
    claim_ready = 1'b1;
    repeat (5) applyStimulus();
    int_in = 4'b0111;
    claim_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    cmp("pre_reset_offer", claim_id, 2);
    midCycleReset();
    applyStimulus();
    applyStimulus();
    cmp("post_reset_id", claim_id, 1);

    // Randomized traffic against the model
    applyReset();
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) int_in = N'($urandom);
      if ($urandom_range(0, 15) == 0) int_en = N'($urandom);
      else if ($urandom_range(0, 7) == 0) int_en = '1;
      claim_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 4) begin
        id = randInflight();
        complete_valid = (id != 0);
        complete_id    = IDW'(id);
      end else if (r == 4) begin
        complete_valid = 1'b1;
        complete_id    = IDW'($urandom);
      end else begin
        complete_valid = 1'b0;
      end
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
